// File: rtl/sobel_window.sv
// Raster-scan 3x3 window generator feeding the Sobel gradient stage.
// Two line buffers plus a 3x3 register window; emits the eight neighbours of each interior pixel.
module sobel_window #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pix,
  output logic       out_valid,
  output logic [8:0] p0,
  output logic [8:0] p1,
  output logic [8:0] p2,
  output logic [8:0] p3,
  output logic [8:0] p5,
  output logic [8:0] p6,
  output logic [8:0] p7,
  output logic [8:0] p8,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  // win_q[column][row]; column 0 is the leftmost, row 0 the top
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic          emit_q, emit_d;
  logic          last_q, last_d;
  logic [7:0]    p_q [8];
  logic [7:0]    p_d [8];
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];

  logic          accept;
  logic          last_pix;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  assign accept   = in_valid && (in_sof || state_q == ACTIVE);
  assign cur_row  = in_sof ? '0 : row_q;
  assign cur_col  = in_sof ? '0 : col_q;
  assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    emit_d  = 1'b0;
    last_d  = 1'b0;
    if (accept) begin
      state_d = ACTIVE;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      if (last_pix) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = '{lb1[cur_col], lb0[cur_col], in_pix};
      emit_d   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_d   = emit_d && last_pix;
    end
  end

  always_comb begin
    out_valid_d  = emit_q;
    frame_done_d = last_q;
    p_d          = p_q;
    if (emit_q) begin
      p_d = '{win_q[0][0], win_q[1][0], win_q[2][0],
              win_q[0][1],              win_q[2][1],
              win_q[0][2], win_q[1][2], win_q[2][2]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '{default: '0};
      emit_q       <= 1'b0;
      last_q       <= 1'b0;
      p_q          <= '{default: '0};
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      emit_q       <= emit_d;
      last_q       <= last_d;
      p_q          <= p_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: line buffers are RAM-like storage with no reset; stale contents never reach a window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= in_pix;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign p0 = {1'b0, p_q[0]};
  assign p1 = {1'b0, p_q[1]};
  assign p2 = {1'b0, p_q[2]};
  assign p3 = {1'b0, p_q[3]};
  assign p5 = {1'b0, p_q[4]};
  assign p6 = {1'b0, p_q[5]};
  assign p7 = {1'b0, p_q[6]};
  assign p8 = {1'b0, p_q[7]};

endmodule

// File: tb/tb_sobel_window.sv
// Self-checking bench for sobel_window: a 4x3 instance for the directed frames and a
// default 64x48 instance for the random frame, checked against a frame-image model.
module tb_sobel_window;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int LW = 64;
  localparam int LH = 48;

  localparam logic [71:0] WIN1 = {9'h000, 9'h001, 9'h002, 9'h010, 9'h012, 9'h020, 9'h021, 9'h022};
  localparam logic [71:0] WIN2 = {9'h001, 9'h002, 9'h003, 9'h011, 9'h013, 9'h021, 9'h022, 9'h023};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pix;

  logic       s_valid, s_fd, l_valid, l_fd;
  logic [8:0] s_p0, s_p1, s_p2, s_p3, s_p5, s_p6, s_p7, s_p8;
  logic [8:0] l_p0, l_p1, l_p2, l_p3, l_p5, l_p6, l_p7, l_p8;

  always #5 clk = ~clk;

  sobel_window #(.IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(s_valid), .p0(s_p0), .p1(s_p1), .p2(s_p2), .p3(s_p3),
    .p5(s_p5), .p6(s_p6), .p7(s_p7), .p8(s_p8), .frame_done(s_fd)
  );

  sobel_window #(.IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(l_valid), .p0(l_p0), .p1(l_p1), .p2(l_p2), .p3(l_p3),
    .p5(l_p5), .p6(l_p6), .p7(l_p7), .p8(l_p8), .frame_done(l_fd)
  );

  typedef struct packed {
    logic        v;
    logic        fd;
    logic [71:0] p;
  } exp_t;

  bit          use_large;
  logic        o_valid, o_fd;
  logic [71:0] o_p;

  assign o_valid = use_large ? l_valid : s_valid;
  assign o_fd    = use_large ? l_fd    : s_fd;
  assign o_p     = use_large ? {l_p0, l_p1, l_p2, l_p3, l_p5, l_p6, l_p7, l_p8}
                             : {s_p0, s_p1, s_p2, s_p3, s_p5, s_p6, s_p7, s_p8};

  logic [7:0]  img [LH][LW];
  exp_t        pend0, pend1;
  logic [71:0] last_p;
  int          win_cnt, fd_cnt;
  logic [71:0] win_seen [8];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs for the input driven two negedges ago are visible now.
  task automatic check_out();
    check("out_valid", 72'(o_valid), 72'(pend1.v));
    check("frame_done", 72'(o_fd), 72'(pend1.fd));
    if (pend1.v) begin
      check("window", o_p, pend1.p);
      last_p = pend1.p;
    end else begin
      check("p_hold", o_p, last_p);
    end
    if (o_valid === 1'b1) begin
      if (win_cnt < 8) win_seen[win_cnt] = o_p;
      win_cnt++;
    end
    if (o_fd === 1'b1) fd_cnt++;
  endtask

  task automatic step(input logic v, input logic sof, input logic [7:0] pix,
                      input bit in_frame, input int r, input int c);
    exp_t e;
    int   w, h;
    w = use_large ? LW : SW;
    h = use_large ? LH : SH;
    @(negedge clk);
    check_out();
    pend1 = pend0;
    e = '0;
    if (v && in_frame) begin
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        e.v  = 1'b1;
        e.fd = (r == h - 1) && (c == w - 1);
        e.p  = {1'b0, img[r-2][c-2], 1'b0, img[r-2][c-1], 1'b0, img[r-2][c],
                1'b0, img[r-1][c-2],                        1'b0, img[r-1][c],
                1'b0, img[r][c-2],   1'b0, img[r][c-1],   1'b0, img[r][c]};
      end
    end
    pend0    = e;
    in_valid = v;
    in_sof   = sof;
    in_pix   = pix;
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    check({tag, "_valid"}, 72'(o_valid), 72'(0));
    check({tag, "_fd"}, 72'(o_fd), 72'(0));
    check({tag, "_p"}, o_p, 72'(0));
    pend0   = '0;
    pend1   = '0;
    last_p  = '0;
    win_cnt = 0;
    fd_cnt  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input logic [7:0] base,
                            input bit gaps, input bit rnd);
    logic [7:0] pix;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix = rnd ? 8'($urandom) : 8'(base + 8'(16 * r + c));
        step(1'b1, (r == 0 && c == 0), pix, 1'b1, r, c);
        if (gaps) step(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
      end
    end
  endtask

  initial begin
    use_large = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pix    = 8'h00;
    #2;
    do_reset("reset");

    // Scenario 1: 4x3 frame, pixels 16r+c, continuous valid.
    send_frame(SW, SH, 8'h00, 1'b0, 1'b0);
    flush();
    check("s1_windows", 72'(win_cnt), 72'(2));
    check("s1_frame_done", 72'(fd_cnt), 72'(1));
    check("s1_win1", win_seen[0], WIN1);
    check("s1_win2", win_seen[1], WIN2);
    do_reset("s1_rst");

    // Scenario 2: same frame with a gap after every pixel.
    send_frame(SW, SH, 8'h00, 1'b1, 1'b0);
    flush();
    check("s2_windows", 72'(win_cnt), 72'(2));
    check("s2_frame_done", 72'(fd_cnt), 72'(1));
    check("s2_win1", win_seen[0], WIN1);
    check("s2_win2", win_seen[1], WIN2);
    do_reset("s2_rst");

    // Scenario 4: abort at (2,1) with a fresh sof, then a full new frame.
    for (int i = 0; i < 9; i++)
      step(1'b1, (i == 0), 8'(8'h80 + 8'(16 * (i / SW) + (i % SW))), 1'b1, i / SW, i % SW);
    send_frame(SW, SH, 8'h00, 1'b0, 1'b0);
    flush();
    check("s4_windows", 72'(win_cnt), 72'(2));
    check("s4_frame_done", 72'(fd_cnt), 72'(1));
    check("s4_win1", win_seen[0], WIN1);
    check("s4_win2", win_seen[1], WIN2);
    do_reset("s4_rst");

    // Scenario 5: reset right as the (2,2) window appears, then pixels without sof.
    for (int i = 0; i < 11; i++)
      step(1'b1, (i == 0), 8'(16 * (i / SW) + (i % SW)), 1'b1, i / SW, i % SW);
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
    check("s5_pre_windows", 72'(win_cnt), 72'(1));
    do_reset("s5_midframe");
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 0, 0);
    flush();
    check("s5_windows", 72'(win_cnt), 72'(0));
    check("s5_frame_done", 72'(fd_cnt), 72'(0));
    do_reset("s5_rst");

    // Scenario 6: two back-to-back frames with distinct contents.
    send_frame(SW, SH, 8'hA0, 1'b0, 1'b0);
    send_frame(SW, SH, 8'h00, 1'b0, 1'b0);
    flush();
    check("s6_windows", 72'(win_cnt), 72'(4));
    check("s6_frame_done", 72'(fd_cnt), 72'(2));
    check("s6_b_win1", win_seen[2], WIN1);
    check("s6_b_win2", win_seen[3], WIN2);

    // Scenario 3: default 64x48 frame of random pixels.
    use_large = 1'b1;
    do_reset("s3_rst");
    send_frame(LW, LH, 8'h00, 1'b0, 1'b1);
    flush();
    check("s3_windows", 72'(win_cnt), 72'((LW - 2) * (LH - 2)));
    check("s3_frame_done", 72'(fd_cnt), 72'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
